// File: rtl/show_pkg.sv
// Shared types and constants for the show-port UART transmitter.
// SHOW_TAG_EN adds a channel-tag frame ahead of every data frame.
package show_pkg;

    localparam int unsigned FrameBits = 10;

    localparam logic [7:0] TagA = 8'h41;
    localparam logic [7:0] TagB = 8'h42;
    localparam logic [7:0] TagC = 8'h43;

`ifdef SHOW_TAG_EN
    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StStop,
        StTagStart,
        StTagData,
        StTagStop
    } tx_state_e;

    function automatic logic [7:0] tag_byte(input logic [1:0] ch);
        logic [7:0] t;
        case (ch)
            2'b01:   t = TagA;
            2'b10:   t = TagB;
            default: t = TagC;
        endcase
        return t;
    endfunction
`else
    typedef enum logic [1:0] {
        StIdle,
        StStart,
        StData,
        StStop
    } tx_state_e;
`endif

endpackage

// File: rtl/show_fifo.sv
// Synchronous FIFO with registered pointers and an occupancy count one bit wider
// than the pointers; a push into a full FIFO succeeds when a pop happens on the same edge.
module show_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push, do_pop;

    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    always_comb begin
        do_pop   = pop_i && !empty_o;
        do_push  = push_i && (!full_o || do_pop);
        wr_ptr_d = do_push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = do_pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = count_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is not reset; the count alone decides what is valid.
    always_ff @(posedge clk_i) begin
        if (!reset_i && do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/show_uart_tx.sv
// Buffers CPU show events and serialises them as 8N1 UART frames on tx.
// Define SHOW_TAG_EN to precede each data frame with an 'A'/'B'/'C' channel tag frame.
module show_uart_tx
    import show_pkg::*;
#(
    parameter int unsigned DEPTH        = 8,
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] ShowE,
    input  logic [7:0] ShowDataE,
    output logic       tx,
    output logic       busy,
    output logic       overflow
);

    localparam int unsigned BW = $clog2(CLKS_PER_BIT);
`ifdef SHOW_TAG_EN
    localparam int unsigned EW = 10;
`else
    localparam int unsigned EW = 8;
`endif

    tx_state_e            state_q, state_d;
    logic [BW-1:0]        baud_q, baud_d;
    logic [2:0]           bit_q, bit_d;
    logic [7:0]           shift_q, shift_d;
    logic                 tx_q, tx_d;
    logic                 overflow_q, overflow_d;
`ifdef SHOW_TAG_EN
    logic [7:0]           hold_q, hold_d;
`endif

    logic                 show_valid;
    logic [EW-1:0]        push_data;
    logic [EW-1:0]        head;
    logic                 pop;
    logic                 fifo_full, fifo_empty;
    logic [$clog2(DEPTH):0] fifo_count;
    logic                 baud_end;

    assign show_valid = (ShowE != 2'b00);
`ifdef SHOW_TAG_EN
    assign push_data = {ShowE, ShowDataE};
`else
    assign push_data = ShowDataE;
`endif

    show_fifo #(
        .WIDTH(EW),
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk_i   (clk),
        .reset_i (reset),
        .push_i  (show_valid),
        .wdata_i (push_data),
        .pop_i   (pop),
        .rdata_o (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    assign baud_end = (baud_q == BW'(CLKS_PER_BIT - 1));

    always_comb begin
        state_d    = state_q;
        baud_d     = baud_q;
        bit_d      = bit_q;
        shift_d    = shift_q;
        pop        = 1'b0;
`ifdef SHOW_TAG_EN
        hold_d     = hold_q;
`endif
        case (state_q)
            StIdle: begin
                if (!fifo_empty) begin
                    pop    = 1'b1;
                    baud_d = '0;
                    bit_d  = '0;
`ifdef SHOW_TAG_EN
                    shift_d = tag_byte(head[9:8]);
                    hold_d  = head[7:0];
                    state_d = StTagStart;
`else
                    shift_d = head;
                    state_d = StStart;
`endif
                end
            end
            StStart: begin
                if (baud_end) begin
                    baud_d  = '0;
                    state_d = StData;
                end else begin
                    baud_d = baud_q + BW'(1);
                end
            end
            StData: begin
                if (baud_end) begin
                    baud_d = '0;
                    if (bit_q == 3'd7) begin
                        state_d = StStop;
                    end else begin
                        bit_d   = bit_q + 3'd1;
                        shift_d = {1'b0, shift_q[7:1]};
                    end
                end else begin
                    baud_d = baud_q + BW'(1);
                end
            end
            StStop: begin
                if (baud_end) begin
                    baud_d  = '0;
                    state_d = StIdle;
                end else begin
                    baud_d = baud_q + BW'(1);
                end
            end
`ifdef SHOW_TAG_EN
            StTagStart: begin
                if (baud_end) begin
                    baud_d  = '0;
                    state_d = StTagData;
                end else begin
                    baud_d = baud_q + BW'(1);
                end
            end
            StTagData: begin
                if (baud_end) begin
                    baud_d = '0;
                    if (bit_q == 3'd7) begin
                        state_d = StTagStop;
                    end else begin
                        bit_d   = bit_q + 3'd1;
                        shift_d = {1'b0, shift_q[7:1]};
                    end
                end else begin
                    baud_d = baud_q + BW'(1);
                end
            end
            StTagStop: begin
                // Data frame follows its tag directly, without an idle cycle.
                if (baud_end) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    shift_d = hold_q;
                    state_d = StStart;
                end else begin
                    baud_d = baud_q + BW'(1);
                end
            end
`endif
            default: state_d = StIdle;
        endcase

        // tx is registered from the next state so each level appears right after its edge.
        tx_d = 1'b1;
        case (state_d)
            StStart: tx_d = 1'b0;
            StData:  tx_d = shift_d[0];
`ifdef SHOW_TAG_EN
            StTagStart: tx_d = 1'b0;
            StTagData:  tx_d = shift_d[0];
`endif
            default: tx_d = 1'b1;
        endcase

        overflow_d = overflow_q | (show_valid && fifo_full && !pop);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            baud_q     <= '0;
            bit_q      <= '0;
            shift_q    <= '0;
            tx_q       <= 1'b1;
            overflow_q <= 1'b0;
`ifdef SHOW_TAG_EN
            hold_q     <= '0;
`endif
        end else begin
            state_q    <= state_d;
            baud_q     <= baud_d;
            bit_q      <= bit_d;
            shift_q    <= shift_d;
            tx_q       <= tx_d;
            overflow_q <= overflow_d;
`ifdef SHOW_TAG_EN
            hold_q     <= hold_d;
`endif
        end
    end

    assign tx       = tx_q;
    assign overflow = overflow_q;
    assign busy     = (fifo_count != '0) || (state_q != StIdle);

endmodule

// File: tb/tb_show_uart_tx.sv
// Self-checking bench for show_uart_tx: a UART receiver model decodes tx and
// compares each frame against a scoreboard of bytes queued when events are driven.
module tb_show_uart_tx;
    import show_pkg::*;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned CPB   = 4;
`ifdef SHOW_TAG_EN
    localparam int unsigned FPE = 2;
`else
    localparam int unsigned FPE = 1;
`endif
    localparam int unsigned FRAME_CYC = FrameBits * CPB;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] ShowE = 2'b00;
    logic [7:0] ShowDataE = 8'h00;
    logic       tx, busy, overflow;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    logic [7:0] sb[$];
    int frame_starts[$];
    int frames_seen = 0;

    typedef struct {
        logic [1:0] ch;
        logic [7:0] data;
        logic [7:0] exp_tag;
    } vec_t;
    vec_t vecs[6];

    show_uart_tx #(
        .DEPTH(DEPTH),
        .CLKS_PER_BIT(CPB)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .ShowE     (ShowE),
        .ShowDataE (ShowDataE),
        .tx        (tx),
        .busy      (busy),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic expect_event(input logic [1:0] ch, input logic [7:0] data, input logic [7:0] tag);
`ifdef SHOW_TAG_EN
        sb.push_back(tag);
`endif
        sb.push_back(data);
    endtask

    function automatic logic [7:0] tag_of(input logic [1:0] ch);
        return 8'h40 + {6'b0, ch};
    endfunction

    task automatic drive_one(input logic [1:0] ch, input logic [7:0] data);
        @(negedge clk);
        ShowE = ch;
        ShowDataE = data;
        expect_event(ch, data, tag_of(ch));
        @(negedge clk);
        ShowE = 2'b00;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while ((busy || sb.size() != 0) && n < 5000) begin
            @(negedge clk);
            n++;
        end
        check(name, (n < 5000) ? 1 : 0, 1);
    endtask

    // Receiver model: samples mid-bit, abandons a frame if reset is seen.
    initial begin : monitor
        logic [9:0] bits;
        bit aborted;
        int st;
        forever begin
            @(posedge clk);
            #1;
            if (!reset && tx === 1'b0) begin
                st = cyc;
                aborted = 1'b0;
                bits = '0;
                for (int k = 0; k < int'(FRAME_CYC); k++) begin
                    if (k > 0) begin
                        @(posedge clk);
                        #1;
                    end
                    if (reset) begin
                        aborted = 1'b1;
                        break;
                    end
                    if (k % CPB == CPB / 2) bits[k / CPB] = tx;
                end
                if (!aborted) begin
                    frames_seen++;
                    frame_starts.push_back(st);
                    check("start_bit", {31'b0, bits[0]}, 0);
                    check("stop_bit", {31'b0, bits[9]}, 1);
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_frame: got %0h expected none", bits[8:1]);
                    end else begin
                        check("frame_byte", {24'b0, bits[8:1]}, {24'b0, sb.pop_front()});
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int n, k, p, f0, s_idx, bad_tx, bad_busy;

        vecs[0] = '{ch: 2'b01, data: 8'hA5, exp_tag: 8'h41};
        vecs[1] = '{ch: 2'b10, data: 8'h3C, exp_tag: 8'h42};
        vecs[2] = '{ch: 2'b11, data: 8'h81, exp_tag: 8'h43};
        vecs[3] = '{ch: 2'b01, data: 8'h00, exp_tag: 8'h41};
        vecs[4] = '{ch: 2'b10, data: 8'hFF, exp_tag: 8'h42};
        vecs[5] = '{ch: 2'b11, data: 8'h5A, exp_tag: 8'h43};

        // Reset state
        repeat (3) @(negedge clk);
        check("reset_tx", {31'b0, tx}, 1);
        check("reset_busy", {31'b0, busy}, 0);
        check("reset_overflow", {31'b0, overflow}, 0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Single event latency and frame length
        @(negedge clk);
        ShowE = 2'b01;
        ShowDataE = 8'hA5;
        expect_event(2'b01, 8'hA5, 8'h41);
        @(negedge clk);
        ShowE = 2'b00;
        check("tx_before_pop", {31'b0, tx}, 1);
        check("busy_after_push", {31'b0, busy}, 1);
        @(negedge clk);
        check("tx_fall_after_pop", {31'b0, tx}, 0);
        n = 1;
        while (busy && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check("busy_cycles", n, 1 + FPE * FRAME_CYC);
        wait_idle("single_drain");

        // Table of single events
        for (int i = 0; i < 6; i++) begin
            f0 = frames_seen;
            @(negedge clk);
            ShowE = vecs[i].ch;
            ShowDataE = vecs[i].data;
            expect_event(vecs[i].ch, vecs[i].data, vecs[i].exp_tag);
            @(negedge clk);
            ShowE = 2'b00;
            wait_idle("vec_drain");
            check("vec_frames", frames_seen - f0, FPE);
            check("vec_overflow", {31'b0, overflow}, 0);
        end

        // DEPTH+2 consecutive events: one popped, DEPTH stored, one dropped
        f0 = frames_seen;
        for (int i = 0; i < int'(DEPTH) + 2; i++) begin
            @(negedge clk);
            if (i == int'(DEPTH) + 1) check("ovf_before_drop", {31'b0, overflow}, 0);
            ShowE = 2'((i % 3) + 1);
            ShowDataE = 8'h10 + 8'(i);
            if (i <= int'(DEPTH)) expect_event(ShowE, ShowDataE, tag_of(ShowE));
        end
        @(negedge clk);
        ShowE = 2'b00;
        check("ovf_set", {31'b0, overflow}, 1);
        wait_idle("ovf_drain");
        check("ovf_frames", frames_seen - f0, (DEPTH + 1) * FPE);
        check("ovf_sticky", {31'b0, overflow}, 1);

        // Reset in the middle of a frame
        @(negedge clk);
        k = cyc + 1;
        ShowE = 2'b10;
        ShowDataE = 8'h69;
        expect_event(2'b10, 8'h69, tag_of(2'b10));
        @(negedge clk);
        ShowE = 2'b00;
        n = 0;
        while (cyc != k + 1 + 3 * int'(CPB) && n < 1000) begin
            @(negedge clk);
            n++;
        end
        reset = 1'b1;
        @(negedge clk);
        check("midreset_tx", {31'b0, tx}, 1);
        check("midreset_busy", {31'b0, busy}, 0);
        check("midreset_overflow", {31'b0, overflow}, 0);
        reset = 1'b0;
        sb.delete();
        repeat (50) @(negedge clk);
        f0 = frames_seen;
        drive_one(2'b01, 8'h96);
        wait_idle("post_reset_drain");
        check("post_reset_frames", frames_seen - f0, FPE);

        // No valid show for 100 cycles
        f0 = frames_seen;
        bad_tx = 0;
        bad_busy = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            ShowDataE = 8'($urandom);
            if (tx !== 1'b1) bad_tx++;
            if (busy !== 1'b0) bad_busy++;
        end
        check("idle_tx_high", bad_tx, 0);
        check("idle_not_busy", bad_busy, 0);
        check("idle_no_frames", frames_seen - f0, 0);

        // Fill the FIFO, then push on exactly the edge that pops it
        f0 = frames_seen;
        k = 0;
        for (int i = 0; i <= int'(DEPTH); i++) begin
            @(negedge clk);
            if (i == 0) k = cyc + 1;
            ShowE = 2'b01;
            ShowDataE = 8'h20 + 8'(i);
            expect_event(ShowE, ShowDataE, tag_of(ShowE));
        end
        @(negedge clk);
        ShowE = 2'b00;
        p = k + 2 + int'(FPE * FRAME_CYC);
        n = 0;
        while (cyc != p - 1 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        ShowE = 2'b11;
        ShowDataE = 8'hC7;
        expect_event(2'b11, 8'hC7, tag_of(2'b11));
        @(negedge clk);
        ShowE = 2'b00;
        check("same_edge_no_overflow", {31'b0, overflow}, 0);
        wait_idle("same_edge_drain");
        check("same_edge_frames", frames_seen - f0, (DEPTH + 2) * FPE);
        check("same_edge_overflow_final", {31'b0, overflow}, 0);

        // Back-to-back 0x00 / 0xFF with one idle cycle between events
        f0 = frames_seen;
        s_idx = frame_starts.size();
        @(negedge clk);
        ShowE = 2'b01;
        ShowDataE = 8'h00;
        expect_event(ShowE, ShowDataE, tag_of(ShowE));
        @(negedge clk);
        ShowE = 2'b10;
        ShowDataE = 8'hFF;
        expect_event(ShowE, ShowDataE, tag_of(ShowE));
        @(negedge clk);
        ShowE = 2'b00;
        wait_idle("b2b_drain");
        check("b2b_frames", frames_seen - f0, 2 * FPE);
        if (frame_starts.size() > s_idx + int'(FPE)) begin
            check("b2b_gap", frame_starts[s_idx + FPE] - frame_starts[s_idx],
                  FPE * FRAME_CYC + 1);
        end else begin
            checks++;
            errors++;
            $display("FAIL b2b_gap: got %0d frame starts expected %0d", frame_starts.size() - s_idx,
                     2 * FPE);
        end

        repeat (5) @(negedge clk);
        check("scoreboard_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/show_uart_tx.md
# show_uart_tx

Debug output stage downstream of the pipelined CPU core: consumes the core's execute-stage show port (`ShowE`, `ShowDataE`), buffers each show event in a small FIFO and serialises it as 8N1 UART frames on a single `tx` line. The CPU never stalls on it; events are dropped when the buffer is full and the loss is flagged.

## Interface
- `DEPTH`, 8: FIFO entries, power of two, ≥2
- `CLKS_PER_BIT`, 16: clock cycles per UART bit, ≥2
- `clk`  in  1  single clock; all state updates on rising edge
- `reset`  in  1  synchronous, active-high; clears all state
- `ShowE`  in  2  show request from CPU execute stage; 2'b00 = none, 01/10/11 = channel A/B/C
- `ShowDataE`  in  8  byte to show, sampled with `ShowE != 0`
- `tx`  out  1  UART serial output, idle high
- `busy`  out  1  FIFO non-empty or frame in progress
- `overflow`  out  1  sticky: a show event was dropped

## Operation
- Push: every edge where `ShowE != 0` writes entry {ShowE, ShowDataE}; accepted if count < DEPTH, or if a pop occurs on the same edge.
- Full with no same-edge pop: event dropped, `overflow` set; cleared only by reset.
- Transmitter FSM states: IDLE, START, DATA, STOP (plus TAG_START, TAG_DATA, TAG_STOP with macro).
- IDLE: on non-empty FIFO, pop head and go to START (or TAG_START).
- START: `tx`=0 for CLKS_PER_BIT cycles → DATA.
- DATA: 8 bits, LSB first, CLKS_PER_BIT each; 3-bit bit counter → STOP after bit 7.
- STOP: `tx`=1 for CLKS_PER_BIT cycles → IDLE. The next frame starts only from IDLE; no back-to-back pop inside STOP.
- Baud counter: counts 0..CLKS_PER_BIT-1, reloads at 0 on every state change.
- Reset (including mid-frame): next edge `tx`=1, FSM IDLE, FIFO empty, `overflow`=0, `busy`=0; partial frame abandoned.

## Timing
- Reset values: `tx`=1, `busy`=0, `overflow`=0.
- `tx` is registered; no combinational path from inputs to any output.
- Event pushed at edge k into an empty, idle block: pop at edge k+1, `tx` falls after edge k+1.
- Frame = 10×CLKS_PER_BIT cycles; with tag, 20×CLKS_PER_BIT per event.
- IDLE costs one cycle between consecutive frames (pop edge).
- `busy` rises after the accepting push edge; falls after the edge leaving STOP with FIFO empty.
- `overflow` rises after the dropping edge.

## Configuration
- `SHOW_TAG_EN` defined: each event sends a tag frame first — 0x41 'A' for ShowE=01, 0x42 'B' for 10, 0x43 'C' for 11 — then the data frame; FIFO entry 10 bits.
- Undefined: data frame only; ShowE used only as valid; FIFO entry 8 bits; TAG_* states absent.

## Structure
- Package `show_pkg`: FSM state enum, tag byte constants, frame bit count (10).
- Sub-module `show_fifo`: synchronous FIFO, parameterised width/DEPTH, push/pop/full/empty, count with one extra bit; same-edge push-when-full-with-pop supported.
- Top holds FSM, baud counter, bit counter, shift register, overflow flag.

## Test plan
- Single event ShowE=01, ShowDataE=0xA5, CLKS_PER_BIT=4 → `tx` falls one edge after push; bits 1,0,1,0,0,1,0,1 then stop; `busy` low after 40 cycles (80 and tag 0x41 first with SHOW_TAG_EN).
- DEPTH+2 consecutive events while idle → first popped, DEPTH stored, 1 dropped; `overflow`=1; exactly DEPTH+1 frames emitted in order.
- Push on same edge as pop with FIFO full → event accepted, `overflow` stays 0.
- Assert reset mid-DATA → `tx`=1 next edge, `busy`=0, `overflow`=0; later event transmits a clean frame.
- ShowE=00 with changing ShowDataE for 100 cycles → `tx` stays 1, `busy` stays 0.
- Events 0x00 and 0xFF back to back → two frames separated by one idle cycle, data bits all 0 / all 1.
